// File: rtl/debug_unit_ctrl.sv
// Debug unit controller: host byte protocol for program load, run/step control
// and a full PC / cycle-count / register / data-memory dump back to the host.
module debug_unit_ctrl #(
   parameter int                 NB_DATA     = 32,
   parameter int                 NB_REG      = 5,
   parameter int                 NB_ADDR     = 8,
   parameter int                 N_MEM_WORDS = 16,
   parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFC000000
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   input  logic               i_halt,
   input  logic [NB_ADDR-1:0] i_pc,
   input  logic [NB_ADDR-1:0] i_count_cycles,
   input  logic [NB_DATA-1:0] i_reg_data,
   input  logic [NB_DATA-1:0] i_mem_data,
   output logic [NB_DATA-1:0] o_inst_load,
   output logic [NB_ADDR-1:0] o_addr_inst_load,
   output logic               o_en_write,
   output logic               o_enable_pipe,
   output logic               o_debug_unit,
   output logic [NB_REG-1:0]  o_addr_reg,
   output logic               o_ctrl_read_debug_reg,
   output logic [NB_ADDR-1:0] o_addr_mem,
   output logic               o_ctrl_addr_debug_mem,
   output logic               o_enable_mem
);

   localparam int N_REGS  = 2 ** NB_REG;
   localparam int N_ITEMS = 2 + N_REGS + N_MEM_WORDS;
   localparam int IW      = $clog2(N_ITEMS);
   localparam int PAD     = NB_DATA - NB_ADDR;

   localparam logic [IW-1:0] ITEM_PC   = IW'(0);
   localparam logic [IW-1:0] ITEM_CYC  = IW'(1);
   localparam logic [IW-1:0] ITEM_REG0 = IW'(2);
   localparam logic [IW-1:0] ITEM_MEM0 = IW'(2 + N_REGS);
   localparam logic [IW-1:0] ITEM_LAST = IW'(N_ITEMS - 1);

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LOAD_WR, S_RUN, S_STEP, S_RD_REQ, S_RD_LATCH, S_TX
   } state_t;

   state_t               state_q, state_d;
   logic [NB_DATA-1:0]   word_q, word_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [NB_ADDR-1:0]   load_addr_q, load_addr_d;
   logic [IW-1:0]        item_q, item_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [NB_DATA-1:0]   tx_word_q, tx_word_d;

   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 en_write_q, en_write_d;
   logic [NB_DATA-1:0]   inst_load_q, inst_load_d;
   logic [NB_ADDR-1:0]   addr_inst_q, addr_inst_d;
   logic                 enable_pipe_q, enable_pipe_d;
   logic                 debug_unit_q, debug_unit_d;
   logic [NB_REG-1:0]    addr_reg_q, addr_reg_d;
   logic                 rd_reg_q, rd_reg_d;
   logic [NB_ADDR-1:0]   addr_mem_q, addr_mem_d;
   logic                 rd_mem_q, rd_mem_d;
   logic                 en_mem_q, en_mem_d;

   function automatic logic [7:0] sel_byte(input logic [NB_DATA-1:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    return w[NB_DATA-1 -: 8];
         2'd1:    return w[NB_DATA-9 -: 8];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   // Next-state logic for the command FSM, load assembler and dump sequencer
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      byte_cnt_d  = byte_cnt_q;
      load_addr_d = load_addr_q;
      item_d      = item_q;
      byte_idx_d  = byte_idx_q;
      tx_word_d   = tx_word_q;
      case (state_q)
         S_IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     state_d    = S_LOAD;
                     word_d     = '0;
                     byte_cnt_d = 2'd0;
                  end
                  CMD_CONT: state_d = S_RUN;
                  CMD_STEP: begin
                     state_d    = i_halt ? S_RD_REQ : S_STEP;
                     item_d     = ITEM_PC;
                     byte_idx_d = 2'd0;
                  end
                  default:  state_d = S_IDLE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (i_rx_valid) begin
               word_d     = {word_q[NB_DATA-9:0], i_rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = S_LOAD_WR;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LOAD_WR: begin
            if (word_q == HALT_WORD) begin
               state_d     = S_IDLE;
               load_addr_d = '0;
            end else begin
               state_d     = S_LOAD;
               load_addr_d = load_addr_q + NB_ADDR'(4);
            end
         end
         S_RUN: begin
            if (i_halt) begin
               state_d    = S_RD_REQ;
               item_d     = ITEM_PC;
               byte_idx_d = 2'd0;
            end else begin
               state_d = S_RUN;
            end
         end
         S_STEP: begin
            state_d    = S_RD_REQ;
            item_d     = ITEM_PC;
            byte_idx_d = 2'd0;
         end
         S_RD_REQ: state_d = S_RD_LATCH;
         S_RD_LATCH: begin
            state_d    = S_TX;
            byte_idx_d = 2'd0;
            if (item_q == ITEM_PC) begin
               tx_word_d = {{PAD{1'b0}}, i_pc};
            end else if (item_q == ITEM_CYC) begin
               tx_word_d = {{PAD{1'b0}}, i_count_cycles};
            end else if (item_q < ITEM_MEM0) begin
               tx_word_d = i_reg_data;
            end else begin
               tx_word_d = i_mem_data;
            end
         end
         S_TX: begin
            if (tx_valid_q && i_tx_ready) begin
               if (byte_idx_q == 2'd3) begin
                  byte_idx_d = 2'd0;
                  if (item_q == ITEM_LAST) begin
                     state_d = S_IDLE;
                     item_d  = ITEM_PC;
                  end else begin
                     state_d = S_RD_REQ;
                     item_d  = item_q + IW'(1);
                  end
               end else begin
                  state_d    = S_TX;
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end else begin
               state_d = S_TX;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output values decoded from the upcoming state so every output leaves a flop
   always_comb begin
      en_write_d    = 1'b0;
      inst_load_d   = '0;
      addr_inst_d   = '0;
      debug_unit_d  = 1'b0;
      enable_pipe_d = 1'b0;
      addr_reg_d    = '0;
      rd_reg_d      = 1'b0;
      addr_mem_d    = '0;
      rd_mem_d      = 1'b0;
      en_mem_d      = 1'b0;
      tx_valid_d    = 1'b0;
      tx_data_d     = 8'h00;
      case (state_d)
         S_LOAD: debug_unit_d = 1'b1;
         S_LOAD_WR: begin
            debug_unit_d = 1'b1;
            en_write_d   = 1'b1;
            inst_load_d  = word_d;
            addr_inst_d  = load_addr_d;
         end
         S_RUN, S_STEP: enable_pipe_d = 1'b1;
         S_RD_REQ, S_RD_LATCH: begin
            // Address is held through RD_LATCH so sync or async readers both work
            if (item_d >= ITEM_MEM0) begin
               addr_mem_d = NB_ADDR'(item_d - ITEM_MEM0);
               rd_mem_d   = 1'b1;
               en_mem_d   = 1'b1;
            end else if (item_d >= ITEM_REG0) begin
               addr_reg_d = NB_REG'(item_d - ITEM_REG0);
               rd_reg_d   = 1'b1;
            end else begin
               rd_reg_d = 1'b0;
            end
         end
         S_TX: begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_byte(tx_word_d, byte_idx_d);
         end
         default: debug_unit_d = 1'b0;
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         word_q        <= '0;
         byte_cnt_q    <= 2'd0;
         load_addr_q   <= '0;
         item_q        <= '0;
         byte_idx_q    <= 2'd0;
         tx_word_q     <= '0;
         tx_data_q     <= 8'h00;
         tx_valid_q    <= 1'b0;
         en_write_q    <= 1'b0;
         inst_load_q   <= '0;
         addr_inst_q   <= '0;
         enable_pipe_q <= 1'b0;
         debug_unit_q  <= 1'b0;
         addr_reg_q    <= '0;
         rd_reg_q      <= 1'b0;
         addr_mem_q    <= '0;
         rd_mem_q      <= 1'b0;
         en_mem_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         byte_cnt_q    <= byte_cnt_d;
         load_addr_q   <= load_addr_d;
         item_q        <= item_d;
         byte_idx_q    <= byte_idx_d;
         tx_word_q     <= tx_word_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         en_write_q    <= en_write_d;
         inst_load_q   <= inst_load_d;
         addr_inst_q   <= addr_inst_d;
         enable_pipe_q <= enable_pipe_d;
         debug_unit_q  <= debug_unit_d;
         addr_reg_q    <= addr_reg_d;
         rd_reg_q      <= rd_reg_d;
         addr_mem_q    <= addr_mem_d;
         rd_mem_q      <= rd_mem_d;
         en_mem_q      <= en_mem_d;
      end
   end

   assign o_tx_data             = tx_data_q;
   assign o_tx_valid            = tx_valid_q;
   assign o_en_write            = en_write_q;
   assign o_inst_load           = inst_load_q;
   assign o_addr_inst_load      = addr_inst_q;
   assign o_enable_pipe         = enable_pipe_q;
   assign o_debug_unit          = debug_unit_q;
   assign o_addr_reg            = addr_reg_q;
   assign o_ctrl_read_debug_reg = rd_reg_q;
   assign o_addr_mem            = addr_mem_q;
   assign o_ctrl_addr_debug_mem = rd_mem_q;
   assign o_enable_mem          = en_mem_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl: command table, program load,
// run/step dumps with a byte scoreboard, back-pressure and reset aborts.
module tb_debug_unit_ctrl;
   localparam int N_MEM      = 16;
   localparam int DUMP_BYTES = 4 * (34 + N_MEM);

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        tx_ready;
   logic        halt;
   logic [7:0]  pc, cyc;
   logic [31:0] reg_data, mem_data;
   logic [31:0] o_inst_load;
   logic [7:0]  o_addr_inst_load;
   logic        o_en_write, o_enable_pipe, o_debug_unit;
   logic [4:0]  o_addr_reg;
   logic        o_ctrl_read_debug_reg;
   logic [7:0]  o_addr_mem;
   logic        o_ctrl_addr_debug_mem, o_enable_mem;

   always #5 clk = ~clk;

   debug_unit_ctrl dut (
      .i_clock(clk), .i_reset(rst),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(tx_ready),
      .i_halt(halt), .i_pc(pc), .i_count_cycles(cyc),
      .i_reg_data(reg_data), .i_mem_data(mem_data),
      .o_inst_load(o_inst_load), .o_addr_inst_load(o_addr_inst_load), .o_en_write(o_en_write),
      .o_enable_pipe(o_enable_pipe), .o_debug_unit(o_debug_unit),
      .o_addr_reg(o_addr_reg), .o_ctrl_read_debug_reg(o_ctrl_read_debug_reg),
      .o_addr_mem(o_addr_mem), .o_ctrl_addr_debug_mem(o_ctrl_addr_debug_mem),
      .o_enable_mem(o_enable_mem)
   );

   // Register file and data memory with one-cycle read latency
   logic [31:0] regfile [32];
   logic [31:0] dmem [N_MEM];
   always @(posedge clk) begin
      reg_data <= regfile[o_addr_reg];
      mem_data <= dmem[o_addr_mem[3:0]];
   end

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic [7:0] exp_tx_q [$];
   wr_t        exp_wr_q [$];
   int         tests = 0;
   int         fails = 0;
   int         xfer_cnt = 0;
   int         wr_cnt = 0;
   int         pipe_cnt = 0;
   int         stall_n = 0;
   logic [7:0] rx_log [256];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic any_out();
      return |{o_tx_data, o_tx_valid, o_en_write, o_inst_load, o_addr_inst_load, o_enable_pipe,
               o_debug_unit, o_addr_reg, o_ctrl_read_debug_reg, o_addr_mem,
               o_ctrl_addr_debug_mem, o_enable_mem};
   endfunction

   // Monitor: drives back-pressure, scores tx bytes and imem writes on the falling edge
   logic       xfer_prev = 1'b0;
   logic       have_held = 1'b0;
   logic [7:0] held;
   int         wait_cnt = 0;
   always @(negedge clk) begin : mon
      wr_t        w;
      logic [8:0] exp_b;
      if (rst) begin
         xfer_prev = 1'b0;
         have_held = 1'b0;
         wait_cnt  = 0;
         tx_ready  = (stall_n == 0);
      end else begin
         if (xfer_prev) begin
            xfer_prev = 1'b0;
            wait_cnt  = 0;
            tx_ready  = (stall_n == 0);
         end else if (!o_tx_valid) begin
            wait_cnt = 0;
            tx_ready = (stall_n == 0);
         end else if (!tx_ready) begin
            wait_cnt++;
            if (wait_cnt >= stall_n) tx_ready = 1'b1;
         end
         if (o_enable_pipe) pipe_cnt++;
         if (o_en_write) begin
            if (exp_wr_q.size() > 0) begin
               w = exp_wr_q.pop_front();
               check("wr_addr", {1'b0, o_addr_inst_load}, {1'b0, w.addr});
               check("wr_data", o_inst_load, w.data);
            end else begin
               check("wr_unexpected", {1'b0, o_addr_inst_load}, 9'h100);
            end
            check("wr_debug_unit", o_debug_unit, 1'b1);
            wr_cnt++;
         end
         if (o_tx_valid) begin
            if (have_held) check("tx_stable", o_tx_data, held);
            if (tx_ready) begin
               exp_b = (exp_tx_q.size() > 0) ? {1'b0, exp_tx_q.pop_front()} : 9'h100;
               check("tx_byte", {1'b0, o_tx_data}, exp_b);
               rx_log[8'(xfer_cnt)] = o_tx_data;
               xfer_cnt++;
               have_held = 1'b0;
               xfer_prev = 1'b1;
            end else begin
               held      = o_tx_data;
               have_held = 1'b1;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_tx_q.delete();
      exp_wr_q.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic push_dump();
      logic [31:0] w;
      for (int i = 0; i < 34 + N_MEM; i++) begin
         if (i == 0)       w = {24'h000000, pc};
         else if (i == 1)  w = {24'h000000, cyc};
         else if (i < 34)  w = regfile[i-2];
         else              w = dmem[i-34];
         for (int b = 3; b >= 0; b--) exp_tx_q.push_back(w[8*b +: 8]);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int   n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (exp_tx_q.size() == 0) && (exp_wr_q.size() == 0) && !o_tx_valid;
      end
      check({name, "_done"}, done, 1'b1);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic       halt;
      logic       exp_debug;
      logic       exp_pipe;
   } vec_t;

   initial begin : wdog
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      vec_t       vecs [8];
      int         base, pbase, wbase;
      logic       act;
      logic [7:0] ld [8];

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;
      pc = 8'h00; cyc = 8'h00;
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      regfile[31] = 32'hDEADBEEF;
      for (int i = 0; i < N_MEM; i++) dmem[i] = $urandom;

      repeat (3) @(negedge clk);
      check("reset_outputs_held", any_out(), 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs_released", any_out(), 1'b0);

      // Command decode table: first cycle after the command byte
      vecs[0] = '{8'h7F, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h4C, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h43, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{8'h53, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h53, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h4C, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{8'h43, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         do_reset();
         halt = vecs[i].halt;
         send_byte(vecs[i].cmd);
         check($sformatf("cmd%0d_debug_unit", i), o_debug_unit, vecs[i].exp_debug);
         check($sformatf("cmd%0d_enable_pipe", i), o_enable_pipe, vecs[i].exp_pipe);
         check($sformatf("cmd%0d_tx_valid", i), o_tx_valid, 1'b0);
         halt = 1'b0;
      end

      // Program load, then a second program restarting at address 0
      do_reset();
      wbase = wr_cnt;
      exp_wr_q.push_back('{8'h00, 32'h20010005});
      exp_wr_q.push_back('{8'h04, 32'hFC000000});
      exp_wr_q.push_back('{8'h00, 32'h12345678});
      exp_wr_q.push_back('{8'h04, 32'hFC000000});
      ld = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
      send_byte(8'h4C);
      check("load_debug_unit_on", o_debug_unit, 1'b1);
      halt = 1'b1;
      for (int i = 0; i < 8; i++) send_byte(ld[i]);
      halt = 1'b0;
      repeat (3) @(negedge clk);
      check("load1_write_count", wr_cnt - wbase, 2);
      check("load1_debug_unit_off", o_debug_unit, 1'b0);
      ld = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFC, 8'h00, 8'h00, 8'h00};
      send_byte(8'h4C);
      for (int i = 0; i < 8; i++) send_byte(ld[i]);
      repeat (3) @(negedge clk);
      check("load2_write_count", wr_cnt - wbase, 4);
      check("load_pipe_idle", o_enable_pipe, 1'b0);
      wait_idle("load", 10);

      // Reset after two load bytes discards the partial word
      do_reset();
      send_byte(8'h4C);
      send_byte(8'hAA);
      send_byte(8'hBB);
      do_reset();
      check("abort_load_outputs", any_out(), 1'b0);
      wbase = wr_cnt;
      exp_wr_q.push_back('{8'h00, 32'h11223344});
      send_byte(8'h4C);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      repeat (3) @(negedge clk);
      check("reload_write_count", wr_cnt - wbase, 1);
      wait_idle("reload", 10);

      // Unknown byte in IDLE: nothing moves
      do_reset();
      send_byte(8'h7F);
      act = 1'b0;
      repeat (20) begin
         @(negedge clk);
         act = act | any_out();
      end
      check("unknown_byte_quiet", act, 1'b0);

      // Continuous run, halt raised after ten enabled cycles
      do_reset();
      pc = 8'h3C; cyc = 8'h91;
      push_dump();
      base  = xfer_cnt;
      pbase = pipe_cnt;
      send_byte(8'h43);
      check("run_pipe_on", o_enable_pipe, 1'b1);
      repeat (9) @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      check("run_pipe_off_after_halt", o_enable_pipe, 1'b0);
      wait_idle("run_dump", 3000);
      halt = 1'b0;
      check("run_pipe_cycles", pipe_cnt - pbase, 10);
      check("run_byte_count", xfer_cnt - base, DUMP_BYTES);
      check("run_pc_msb_first", {rx_log[8'(base)], rx_log[8'(base+1)], rx_log[8'(base+2)],
                                 rx_log[8'(base+3)]}, 32'h0000003C);

      // Single step without halt: one enable pulse
      do_reset();
      pc = 8'h40; cyc = 8'h01;
      push_dump();
      base  = xfer_cnt;
      pbase = pipe_cnt;
      send_byte(8'h53);
      wait_idle("step_dump", 3000);
      check("step_pipe_cycles", pipe_cnt - pbase, 1);
      check("step_byte_count", xfer_cnt - base, DUMP_BYTES);

      // Step with halt already set, host stalling about five cycles per byte
      stall_n = 5;
      do_reset();
      halt = 1'b1;
      pc = 8'hFF; cyc = 8'h7E;
      push_dump();
      base  = xfer_cnt;
      pbase = pipe_cnt;
      send_byte(8'h53);
      wait_idle("stall_dump", 5000);
      check("stall_pipe_cycles", pipe_cnt - pbase, 0);
      check("stall_byte_count", xfer_cnt - base, DUMP_BYTES);
      check("stall_r31_bytes", {rx_log[8'(base+132)], rx_log[8'(base+133)], rx_log[8'(base+134)],
                                rx_log[8'(base+135)]}, 32'hDEADBEEF);
      stall_n = 0;

      // Reset in the middle of a dump stops transmission at once
      do_reset();
      push_dump();
      base = xfer_cnt;
      send_byte(8'h53);
      for (int n = 0; n < 400 && (xfer_cnt - base) < 10; n++) @(negedge clk);
      check("abort_dump_started", (xfer_cnt - base) >= 10, 1'b1);
      halt = 1'b0;
      do_reset();
      base = xfer_cnt;
      act  = 1'b0;
      repeat (30) begin
         @(negedge clk);
         act = act | o_tx_valid;
      end
      check("abort_dump_tx_valid", act, 1'b0);
      check("abort_dump_no_bytes", xfer_cnt - base, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/debug_unit_ctrl.md
DEBUG_UNIT_CTRL -- requirements
Module: debug_unit_ctrl

Interface
REQ-001 Parameter NB_DATA, 32, data/instruction word width.
REQ-002 Parameter NB_REG, 5, register address width.
REQ-003 Parameter NB_ADDR, 8, instruction/data memory address width (matches ADDRWIDTH).
REQ-004 Parameter N_MEM_WORDS, 16, data-memory words dumped per report.
REQ-005 Parameter HALT_WORD, 32'hFC000000, instruction word that ends a program load.
REQ-006 Design SHALL use one clock; reset is asynchronous and active-high.
REQ-007 i_clock  in  1  sole clock; all state updates on rising edge.
REQ-008 i_reset  in  1  asynchronous, active-high reset.
REQ-009 i_rx_data  in  8  received host byte; i_rx_valid  in  1  one-cycle strobe, byte valid.
REQ-010 o_tx_data  out  8  byte to host; o_tx_valid  out  1; i_tx_ready  in  1; byte transferred when both high on an edge.
REQ-011 i_halt  in  1  pipeline halt reached; i_pc  in  NB_ADDR  current PC; i_count_cycles  in  NB_ADDR  cycle counter.
REQ-012 i_reg_data  in  NB_DATA  register-file debug read data; i_mem_data  in  NB_DATA  data-memory debug read data; both valid one cycle after address presented.
REQ-013 o_inst_load  out  NB_DATA; o_addr_inst_load  out  NB_ADDR; o_en_write  out  1  one-cycle instruction-memory write strobe.
REQ-014 o_enable_pipe  out  1  pipeline advance; o_debug_unit  out  1  high while debug unit owns instruction memory (load in progress).
REQ-015 o_addr_reg  out  NB_REG; o_ctrl_read_debug_reg  out  1; o_addr_mem  out  NB_ADDR; o_ctrl_addr_debug_mem  out  1; o_enable_mem  out  1.

Function
REQ-016 Commands (byte in IDLE): 0x4C 'L' load, 0x43 'C' continuous run, 0x53 'S' single step; any other byte SHALL be ignored.
REQ-017 States: IDLE, LOAD, LOAD_WR, RUN, STEP, RD_REQ, RD_LATCH, TX; dump sequence handled by RD_REQ/RD_LATCH/TX with an item counter.
REQ-018 LOAD: bytes assembled MSB first into a 32-bit word; after 4th byte go LOAD_WR.
REQ-019 LOAD_WR: o_en_write=1 for exactly one cycle with o_inst_load=word, o_addr_inst_load=current address; address then +4, wrapping modulo 2^NB_ADDR.
REQ-020 If written word == HALT_WORD, return to IDLE and reset load address to 0; else back to LOAD.
REQ-021 o_debug_unit SHALL be 1 in LOAD and LOAD_WR, 0 otherwise.
REQ-022 RUN: o_enable_pipe=1 every cycle until i_halt sampled 1; then o_enable_pipe=0 next cycle and enter dump.
REQ-023 STEP: o_enable_pipe=1 for exactly one cycle, then dump; if i_halt already 1 on command, no enable pulse, dump only.
REQ-024 Dump order: PC (zero-extended to 32), cycle count (zero-extended), registers 0..31, data-memory words 0..N_MEM_WORDS-1; each word 4 bytes MSB first; total 4*(34+N_MEM_WORDS) bytes.
REQ-025 Register/memory word: RD_REQ drives address with o_ctrl_read_debug_reg or o_ctrl_addr_debug_mem/o_enable_mem =1; RD_LATCH captures data next cycle; TX sends.
REQ-026 TX: o_tx_valid held high with stable o_tx_data until i_tx_ready; next byte presented no earlier than the cycle after transfer.
REQ-027 After final byte transferred, return to IDLE.
REQ-028 i_rx_valid in any state other than IDLE/LOAD SHALL be ignored (no buffering).
REQ-029 i_halt asserted during LOAD is ignored; o_enable_pipe SHALL be 0 in all states except RUN/STEP.

Reset
REQ-030 On i_reset: state IDLE, load address 0, counters 0, all outputs 0 (o_tx_data=0, o_tx_valid=0, o_en_write=0, o_enable_pipe=0, o_debug_unit=0, addresses 0, read controls 0).
REQ-031 Reset mid-load or mid-dump SHALL abort immediately; partial word discarded, no further tx bytes.

Verification
REQ-032 'L', bytes 20 01 00 05, FC 00 00 00 -> write 0x20010005 @0 then 0xFC000000 @4, two single-cycle o_en_write pulses, back to IDLE.
REQ-033 'C', i_halt raised 10 cycles later -> o_enable_pipe high exactly through halt cycle, then 4*(34+16)=200 bytes sent, first 4 = PC MSB first.
REQ-034 'S' with i_halt=0 -> single o_enable_pipe pulse, 200-byte dump; 'S' with i_halt=1 -> no pulse, dump only.
REQ-035 Dump with i_tx_ready held low 5 cycles per byte -> o_tx_data stable while waiting, no byte lost or duplicated; register 31 value 0xDEADBEEF appears as DE AD BE EF.
REQ-036 Reset asserted after 2 load bytes, then new 'L' with 4 bytes -> written to address 0 with only the new bytes; unknown byte 0x7F in IDLE -> no output activity.
